// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes for the 1-to-4 sequential demux.
package demux_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_chan_buf.sv
// demux_chan_buf: one-entry output buffer with load and drain.
module demux_chan_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load wins over a drain so a same-cycle refill never leaves a bubble.
    always_comb begin
        valid_d = load | (valid_q & ~drain);
        data_d  = load ? in_data : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/demux1x4_seq.sv
// demux1x4_seq: routes input words to one of four buffered channels,
// by explicit select or round-robin.
module demux1x4_seq
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]        rr_ptr,
    output logic [CNT_W-1:0]        acc_cnt
);
    sel_t             t;
    logic             acc;
    sel_t             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        t         = mode ? rr_ptr_q : in_sel;
        in_ready  = ~out_valid[t] | out_ready[t];
        acc       = in_valid & in_ready;
        rr_ptr_d  = (acc & mode) ? rr_ptr_q + SEL_W'(1) : rr_ptr_q;
        acc_cnt_d = acc ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            acc_cnt_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_chan_buf #(.WIDTH(WIDTH)) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (acc && t == SEL_W'(k)),
            .drain   (out_valid[k] & out_ready[k]),
            .in_data (in_data),
            .valid   (out_valid[k]),
            .data    (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign rr_ptr  = rr_ptr_q;
    assign acc_cnt = acc_cnt_q;
endmodule

// File: tb/tb_demux1x4_seq.sv
// tb_demux1x4_seq: directed scenarios plus random traffic against a
// per-channel occupancy model.
module tb_demux1x4_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_sel = '0;
    logic [7:0]  in_data = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data;
    logic [1:0]  rr_ptr;
    logic [7:0]  acc_cnt;

    int errs = 0;
    int checks = 0;

    bit       ev[4];
    int       ed[4];
    int       eptr = 0;
    int       ecnt = 0;

    demux1x4_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            ev[k] = 1'b0;
            ed[k] = 0;
        end
        eptr = 0;
        ecnt = 0;
    endtask

    task automatic check_state(input string tag);
        logic [3:0]  v;
        logic [31:0] d;
        int          tgt;
        tgt = mode ? eptr : int'(in_sel);
        for (int k = 0; k < 4; k++) begin
            v[k] = ev[k];
            d[k*8 +: 8] = 8'(ed[k]);
        end
        chk({tag, ".ready"}, 32'(in_ready), 32'(!ev[tgt] || out_ready[tgt]));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".ptr"}, 32'(rr_ptr), 32'(eptr));
        chk({tag, ".cnt"}, 32'(acc_cnt), 32'(ecnt));
    endtask

    // Drive one cycle of inputs, check what the DUT shows before the edge,
    // then advance the model across the edge.
    task automatic step(input string tag, input logic m, input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic [3:0] r);
        int  tgt;
        bit  acc;
        @(negedge clk);
        mode = m; in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
        check_state(tag);
        tgt = m ? eptr : int'(s);
        acc = v && (!ev[tgt] || r[tgt]);
        for (int k = 0; k < 4; k++)
            if (ev[k] && r[k]) ev[k] = 1'b0;
        if (acc) begin
            ev[tgt] = 1'b1;
            ed[tgt] = int'(d);
            if (m) eptr = (eptr + 1) % 4;
            ecnt = (ecnt + 1) % 256;
        end
        @(posedge clk);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.data", out_data, 0);
        chk("rst.ptr", 32'(rr_ptr), 0);
        chk("rst.cnt", 32'(acc_cnt), 0);
        chk("rst.ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // explicit select, one word per channel
        step("sel0", 0, 1, 0, 8'h11, 4'hF);
        step("sel1", 0, 1, 1, 8'h22, 4'hF);
        step("sel2", 0, 1, 2, 8'h33, 4'hF);
        step("sel3", 0, 1, 3, 8'h44, 4'hF);
        step("sel_idle", 0, 0, 0, 8'h00, 4'hF);
        chk("sel.cnt4", 32'(acc_cnt), 4);

        // stall on a full channel, then refill without a bubble
        step("st1", 0, 1, 2, 8'h5A, 4'hB);
        step("st2", 0, 1, 2, 8'h6B, 4'hB);
        chk("st.blocked", 32'(in_ready), 0);
        step("st3", 0, 1, 2, 8'h6B, 4'hF);
        step("st4", 0, 0, 2, 8'h00, 4'hB);
        chk("st.nobubble", 32'(out_data[23:16]), 32'h6B);
        step("st5", 0, 0, 0, 8'h00, 4'hF);

        // round-robin
        for (int i = 0; i < 6; i++)
            step("rr", 1, 1, 2'(i + 3), 8'(8'hA0 + i), 4'hF);
        step("rr_idle", 1, 0, 0, 8'h00, 4'hF);
        chk("rr.end", 32'(rr_ptr), 2);

        // advance pointer to 1, detour through mode 0, come back
        step("mx0", 1, 1, 0, 8'hB2, 4'hF);
        step("mx1", 1, 1, 0, 8'hB3, 4'hF);
        step("mx2", 1, 1, 0, 8'hB0, 4'hF);
        step("mx3", 0, 1, 3, 8'hC0, 4'hF);
        step("mx4", 0, 1, 2, 8'hC1, 4'hF);
        step("mx5", 1, 1, 3, 8'hD1, 4'hF);
        step("mx6", 1, 0, 0, 8'h00, 4'h0);
        chk("mx.ch1", 32'(out_valid), 32'h2);
        chk("mx.data1", 32'(out_data[15:8]), 32'hD1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rnd", 1'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom),
                 8'($urandom), 4'($urandom));

        // counter wrap after 256 accepts from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check_state("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++)
            step("wrap", 1'(i % 2), 1, 2'($urandom), 8'($urandom), 4'hF);
        step("wrap_idle", 0, 0, 0, 8'h00, 4'hF);
        chk("wrap.cnt", 32'(acc_cnt), 0);

        // reset with every channel full, between edges
        for (int i = 0; i < 4; i++)
            step("fill", 0, 1, 2'(i), 8'(8'hE0 + i), 4'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.valid", 32'(out_valid), 0);
        chk("mid.data", out_data, 0);
        chk("mid.ptr", 32'(rr_ptr), 0);
        chk("mid.cnt", 32'(acc_cnt), 0);
        chk("mid.ready", 32'(in_ready), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post0", 1, 1, 3, 8'h77, 4'h0);
        step("post1", 1, 0, 0, 8'h00, 4'h0);
        chk("post.first", 32'(out_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
